// File: rtl/cmd_pkg.sv
// Shared types and constants for the command frame receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_OP,
    GET_ARG,
    GET_CHK,
    ISSUE
  } state_e;

  typedef enum logic [3:0] {
    OP_START     = 4'd1,
    OP_ROCK      = 4'd2,
    OP_SCISSORS  = 4'd3,
    OP_PAPER     = 4'd4,
    OP_CLR_SCORE = 4'd5
  } op_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;
  localparam logic [3:0] OP_MAX        = 4'd5;

  // An opcode byte is legal only with a clear upper nibble and a known command.
  function automatic logic op_is_valid(input logic [7:0] op);
    return (op[7:4] == 4'd0) && (op[3:0] >= OP_START) && (op[3:0] <= OP_MAX);
  endfunction

endpackage

// File: rtl/byte_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last byte strobe.
// Latency: expire pulses in the cycle the count sits at TIMEOUT_CYC-1.
// Backpressure: none; clear always wins over counting and expiry.
module byte_timer #(
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  // A byte in the same cycle as the last count suppresses the expiry.
  assign expire = en && !clear && (cnt == LAST);

  // Restart on every byte, advance only while a frame is in progress,
  // and wrap after expiry so the pulse is a single cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cmd_frame_ctrl.sv
// Decodes SYNC/OP/ARG/CHK byte frames into a single held command.
// Latency: cmd_valid rises one cycle after the CHK byte strobe.
// Backpressure: command held until cmd_ready; bytes arriving meanwhile are dropped and counted.
module cmd_frame_ctrl
  import cmd_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 500000,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [3:0] cmd_op,
  output logic [7:0] cmd_arg,
  output logic       busy,
  output logic [7:0] err_cnt
);

  state_e     state_q, state_d;
  logic [7:0] op_q, arg_q, err_q;
  logic       ld_op, ld_arg, err_inc;
  logic       timer_en, expire, frame_ok;

  assign timer_en = (state_q == GET_OP) || (state_q == GET_ARG) || (state_q == GET_CHK);
  assign frame_ok = (rx_data == (op_q ^ arg_q)) && op_is_valid(op_q);

  byte_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (rx_data_valid),
    .en     (timer_en),
    .expire (expire)
  );

  // Next-state and strobes; a byte strobe always beats a timer expiry.
  always_comb begin
    state_d = state_q;
    ld_op   = 1'b0;
    ld_arg  = 1'b0;
    err_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_data_valid && (rx_data == SYNC_BYTE)) state_d = GET_OP;
      end
      GET_OP: begin
        if (rx_data_valid) begin
          ld_op   = 1'b1;
          state_d = GET_ARG;
        end else if (expire) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end
      end
      GET_ARG: begin
        if (rx_data_valid) begin
          ld_arg  = 1'b1;
          state_d = GET_CHK;
        end else if (expire) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end
      end
      GET_CHK: begin
        if (rx_data_valid) begin
          if (frame_ok) begin
            state_d = ISSUE;
          end else begin
            err_inc = 1'b1;
            state_d = IDLE;
          end
        end else if (expire) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (rx_data_valid) err_inc = 1'b1;
        if (cmd_ready)     state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any partial frame or pending command.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Field latches; they only load in GET_OP/GET_ARG so they hold through ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= '0;
      arg_q <= '0;
    end else begin
      if (ld_op)  op_q  <= rx_data;
      if (ld_arg) arg_q <= rx_data;
    end
  end

  // Saturating reject counter.
  always_ff @(posedge clk) begin
    if (rst)                            err_q <= '0;
    else if (err_inc && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
  end

  assign cmd_valid = (state_q == ISSUE);
  assign cmd_op    = op_q[3:0];
  assign cmd_arg   = arg_q;
  assign busy      = (state_q != IDLE);
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// Directed bench for cmd_frame_ctrl with hand-computed expectations.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: cmd_ready driven directly per scenario.
module tb_cmd_frame_ctrl;

  localparam int T = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_data_valid = 1'b0;
  logic       cmd_valid;
  logic       cmd_ready = 1'b1;
  logic [3:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       busy;
  logic [7:0] err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cmd_frame_ctrl #(
    .TIMEOUT_CYC (T),
    .SYNC_BYTE   (8'hAA)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_arg       (cmd_arg),
    .busy          (busy),
    .err_cnt       (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; the byte is sampled at the next rising edge,
  // and the task returns on the falling edge just after it.
  task automatic send_byte(input logic [7:0] b);
    rx_data       = b;
    rx_data_valid = 1'b1;
    @(negedge clk);
    rx_data_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] arg, input logic [7:0] ck);
    send_byte(8'hAA);
    send_byte(op);
    send_byte(arg);
    send_byte(ck);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_valid", cmd_valid, 0);
    chk("rst_busy",  busy,      0);
    chk("rst_err",   err_cnt,   0);
    chk("rst_op",    cmd_op,    0);
    chk("rst_arg",   cmd_arg,   0);

    // AA 02 10 12, ready high: one-cycle command
    cmd_ready = 1'b1;
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h10);
    chk("mid_valid", cmd_valid, 0);
    chk("mid_busy",  busy,      1);
    send_byte(8'h12);
    chk("rock_valid", cmd_valid, 1);
    chk("rock_op",    cmd_op,    2);
    chk("rock_arg",   cmd_arg,   8'h10);
    chk("rock_err",   err_cnt,   0);
    @(negedge clk);
    chk("rock_drop", cmd_valid, 0);
    chk("rock_idle", busy,      0);

    // Bad checksum, then a good START
    send_frame(8'h03, 8'h05, 8'h07);
    chk("badck_valid", cmd_valid, 0);
    chk("badck_err",   err_cnt,   1);
    chk("badck_idle",  busy,      0);
    send_frame(8'h01, 8'h00, 8'h01);
    chk("start_valid", cmd_valid, 1);
    chk("start_op",    cmd_op,    1);
    @(negedge clk);
    chk("start_drop", cmd_valid, 0);

    // Noise in IDLE is silently dropped
    send_byte(8'h55);
    chk("noise_err",  err_cnt, 1);
    chk("noise_busy", busy,    0);

    // Invalid opcodes
    send_frame(8'h09, 8'h00, 8'h09);
    chk("op9_err", err_cnt, 2);
    send_frame(8'h13, 8'h00, 8'h13);
    chk("op13_err", err_cnt, 3);
    send_frame(8'h00, 8'h00, 8'h00);
    chk("op0_err", err_cnt, 4);
    chk("op0_valid", cmd_valid, 0);

    // Sync value inside a frame is plain data
    send_frame(8'h02, 8'hAA, 8'hA8);
    chk("syncarg_valid", cmd_valid, 1);
    chk("syncarg_arg",   cmd_arg,   8'hAA);
    chk("syncarg_err",   err_cnt,   4);
    @(negedge clk);

    // Timeout after AA 04
    send_byte(8'hAA); send_byte(8'h04);
    repeat (T-1) @(negedge clk);
    chk("to_pre_busy", busy,    1);
    chk("to_pre_err",  err_cnt, 4);
    @(negedge clk);
    chk("to_busy", busy,    0);
    chk("to_err",  err_cnt, 5);

    // Byte on the expiry edge wins
    send_byte(8'hAA); send_byte(8'h04);
    repeat (T-1) @(negedge clk);
    send_byte(8'h00);
    chk("edge_busy", busy,    1);
    chk("edge_err",  err_cnt, 5);
    send_byte(8'h04);
    chk("edge_valid", cmd_valid, 1);
    chk("edge_op",    cmd_op,    4);
    @(negedge clk);

    // Overrun while held
    do_reset();
    cmd_ready = 1'b0;
    send_frame(8'h05, 8'h00, 8'h05);
    chk("hold_valid", cmd_valid, 1);
    send_byte(8'h11);
    send_byte(8'h22);
    chk("ovr_valid", cmd_valid, 1);
    chk("ovr_op",    cmd_op,    5);
    chk("ovr_arg",   cmd_arg,   0);
    chk("ovr_err",   err_cnt,   2);
    @(negedge clk);
    chk("ovr_still", cmd_valid, 1);
    cmd_ready = 1'b1;
    chk("ovr_pre", cmd_valid, 1);
    @(negedge clk);
    chk("ovr_clr",  cmd_valid, 0);
    chk("ovr_idle", busy,      0);
    chk("ovr_err2", err_cnt,   2);

    // Reset during ISSUE discards the command
    cmd_ready = 1'b0;
    send_frame(8'h01, 8'h07, 8'h06);
    chk("iss_valid", cmd_valid, 1);
    do_reset();
    cmd_ready = 1'b1;
    chk("issrst_valid", cmd_valid, 0);
    chk("issrst_err",   err_cnt,   0);
    chk("issrst_op",    cmd_op,    0);

    // Reset mid-frame, then the first frame after reset is processed
    send_byte(8'hAA); send_byte(8'h02);
    do_reset();
    chk("midrst_busy", busy,    0);
    chk("midrst_err",  err_cnt, 0);
    send_frame(8'h03, 8'h03, 8'h00);
    chk("post_valid", cmd_valid, 1);
    chk("post_op",    cmd_op,    3);
    @(negedge clk);

    // Saturation
    for (int i = 0; i < 254; i++) send_frame(8'h03, 8'h05, 8'h07);
    chk("sat_254", err_cnt, 254);
    send_frame(8'h03, 8'h05, 8'h07);
    chk("sat_255", err_cnt, 255);
    for (int i = 0; i < 5; i++) send_frame(8'h03, 8'h05, 8'h07);
    chk("sat_hold", err_cnt, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cmd_frame_ctrl.md
CMD_FRAME_CTRL -- requirements
Module: cmd_frame_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 500000, the maximum number of clk cycles allowed between bytes of one frame (10 ms at 50 MHz).
REQ-002 The block SHALL have parameter SYNC_BYTE, default 8'hAA, the frame header value.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock, the same domain as the uart_rx outputs.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rx_data  input  8  received byte.
REQ-007 rx_data_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-008 cmd_valid  output  1  a decoded command is available.
REQ-009 cmd_ready  input  1  the downstream game controller accepts the command.
REQ-010 cmd_op  output  4  command opcode: 1=START, 2=ROCK, 3=SCISSORS, 4=PAPER, 5=CLR_SCORE.
REQ-011 cmd_arg  output  8  command argument byte.
REQ-012 busy  output  1  a frame is being received or a command is pending.
REQ-013 err_cnt  output  8  count of rejected frames, saturating.

Function
REQ-014 Frame format SHALL be four bytes: SYNC_BYTE, OP, ARG, CHK, where the expected CHK = OP xor ARG.
REQ-015 The FSM SHALL have states IDLE, GET_OP, GET_ARG, GET_CHK and ISSUE.
REQ-016 IDLE: a byte equal to SYNC_BYTE SHALL move the FSM to GET_OP; any other byte is silently dropped with no err_cnt change.
REQ-017 GET_OP, GET_ARG: each received byte SHALL be latched and the FSM SHALL advance one state; a value equal to SYNC_BYTE is treated as data, with no resync.
REQ-018 GET_CHK: on a received byte, a frame SHALL be accepted only if the checksum matches, OP[7:4]==0 and OP[3:0] is in 1..5.
REQ-019 An accepted frame SHALL move the FSM to ISSUE; a rejected frame SHALL move it to IDLE and increment err_cnt.
REQ-020 cmd_valid SHALL rise in the cycle after the CHK byte strobe, giving a latency of 1 cycle.
REQ-021 cmd_op and cmd_arg SHALL remain stable while cmd_valid is high.
REQ-022 ISSUE: when cmd_valid and cmd_ready are both high, the FSM SHALL go to IDLE and cmd_valid SHALL be low in the next cycle.
REQ-023 If cmd_ready is already high in the first ISSUE cycle, cmd_valid SHALL be high for exactly one cycle.
REQ-024 Bytes received in ISSUE SHALL be dropped and each one SHALL increment err_cnt (overrun).
REQ-025 The inter-byte timer SHALL clear on every rx_data_valid and count only in GET_OP, GET_ARG and GET_CHK.
REQ-026 When the timer reaches TIMEOUT_CYC-1 without a byte, the FSM SHALL go to IDLE and increment err_cnt.
REQ-027 If a byte strobe and timer expiry occur in the same cycle, the byte SHALL take priority and no timeout is recorded.
REQ-028 err_cnt SHALL saturate at 255 and never wrap.
REQ-029 busy SHALL be high whenever the state is not IDLE.

Reset
REQ-030 On rst, the state SHALL be IDLE, and cmd_valid, cmd_op, cmd_arg, err_cnt, the timer and busy SHALL all be 0.
REQ-031 rst asserted mid-frame or during ISSUE SHALL discard the frame or pending command, with no err_cnt increment.
REQ-032 The first byte strobe after rst deasserts SHALL be processed normally.

Structure
REQ-033 Package cmd_pkg SHALL hold: the state enum, the opcode enum (OP_START..OP_CLR_SCORE), SYNC_BYTE_DEF, and OP_MAX=5.
REQ-034 The block SHALL contain one sub-module, byte_timer (parameter TIMEOUT_CYC; inputs clear and en; output expire, a one-cycle pulse).
REQ-035 Everything else SHALL be a single FSM plus a latch register file in cmd_frame_ctrl.

Verification
REQ-036 Sending AA 02 10 12 with cmd_ready=1 SHALL give cmd_valid for one cycle, 1 cycle after the 12 strobe, with cmd_op=2, cmd_arg=8'h10 and err_cnt=0.
REQ-037 Sending AA 03 05 07 (bad CHK, expected 06) SHALL produce no cmd_valid and err_cnt=1; a following AA 01 00 01 SHALL issue START.
REQ-038 Sending AA 09 00 09 SHALL be rejected as an invalid opcode, with err_cnt incremented.
REQ-039 Sending AA 04 then idling TIMEOUT_CYC cycles SHALL return the FSM to IDLE with err_cnt+1; a byte exactly on the expiry cycle SHALL not time out.
REQ-040 With cmd_ready=0, sending AA 05 00 05 and then 2 more bytes SHALL hold cmd_valid with stable op=5 and set err_cnt=2; cmd_ready=1 SHALL then clear cmd_valid the next cycle.
REQ-041 Asserting rst after AA 02 SHALL leave state IDLE and err_cnt=0, and 260 bad frames SHALL leave err_cnt=255.
